// File: rtl/sdcard_block_seq.sv
// Single-block (CMD17) SPI SD-card read sequencer driving the byte engine and block buffer.
// Define SDCARD_SEQ_CRC_EN to check the trailing CRC16 (error 5); otherwise the CRC bytes are discarded.
module sdcard_block_seq #(
  parameter int R1_TRIES    = 8,
  parameter int TOKEN_TRIES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [0:31] lba,
  output logic        busy,
  output logic        done,
  output logic [0:2]  err_code,
  output logic        sd_cs,
  output logic        eng_go,
  output logic [0:7]  eng_tx,
  input  logic        eng_busy,
  input  logic [0:7]  eng_rx,
  input  logic [0:15] eng_crc16,
  output logic        eng_crc_clr,
  output logic        buf_we,
  output logic [0:8]  buf_adr,
  output logic [0:7]  buf_d
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_TAIL
  } state_t;

  // Per-byte phase: GO drives eng_go, SKIP masks the engine's busy rise, WAIT polls for completion.
  // CLR is a dedicated cycle for eng_crc_clr between the token and the first data byte.
  typedef enum logic [1:0] {
    PH_GO, PH_SKIP, PH_WAIT, PH_CLR
  } ph_t;

  localparam logic [15:0] R1_LIM  = 16'(R1_TRIES);
  localparam logic [15:0] TOK_LIM = 16'(TOKEN_TRIES);

  state_t      state_q, state_d;
  ph_t         ph_q, ph_d;
  logic [15:0] cnt_q, cnt_d;
  logic [0:31] lba_q, lba_d;
  logic [0:7]  tx_q, tx_d;
  logic [0:2]  err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cs_q, cs_d;
  logic        abort_q, abort_d;
  logic        we_q, we_d;
  logic [0:8]  adr_q, adr_d;
  logic [0:7]  bd_q, bd_d;

  logic        complete;
  logic        fin;
  logic [0:2]  fin_code;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [0:31] a);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'h51;
      3'd1:    b = a[0:7];
      3'd2:    b = a[8:15];
      3'd3:    b = a[16:23];
      3'd4:    b = a[24:31];
      default: b = 8'h01;
    endcase
    return b;
  endfunction

`ifndef SDCARD_SEQ_CRC_EN
  logic crc_unused;
  assign crc_unused = ^eng_crc16;
`endif

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q;
    lba_d    = lba_q;
    tx_d     = tx_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cs_d     = cs_q;
    abort_d  = abort_q;
    we_d     = 1'b0;
    adr_d    = adr_q;
    bd_d     = bd_q;
    fin      = 1'b0;
    fin_code = 3'd0;
    complete = (ph_q == PH_WAIT) && !eng_busy;

    case (ph_q)
      PH_GO:   ph_d = PH_SKIP;
      PH_SKIP: ph_d = PH_WAIT;
      default: ph_d = ph_q;
    endcase

    if (state_q == S_IDLE) begin
      // The done cycle is already IDLE, so a start coinciding with done is dropped here.
      if (start && !done_q) begin
        lba_d   = lba;
        err_d   = 3'd0;
        busy_d  = 1'b1;
        cs_d    = 1'b1;
        abort_d = 1'b0;
        cnt_d   = 16'd0;
        tx_d    = 8'h51;
        ph_d    = PH_GO;
        state_d = S_CMD;
      end
    end else begin
      if (abort) abort_d = 1'b1;
      // A byte that completes under a pending abort is discarded, not processed.
      if ((abort_q || abort) && (complete || ph_q == PH_CLR)) begin
        fin      = 1'b1;
        fin_code = 3'd6;
      end else if (ph_q == PH_CLR) begin
        ph_d = PH_GO;
        tx_d = 8'hFF;
      end else if (complete) begin
        ph_d = PH_GO;
        tx_d = 8'hFF;
        case (state_q)
          S_CMD: begin
            if (cnt_q == 16'd5) begin
              cnt_d   = 16'd0;
              state_d = S_R1;
            end else begin
              cnt_d = cnt_q + 16'd1;
              tx_d  = cmd_byte(cnt_q[2:0] + 3'd1, lba_q);
            end
          end
          S_R1: begin
            if (eng_rx == 8'hFF) begin
              cnt_d = cnt_q + 16'd1;
              if (cnt_q + 16'd1 == R1_LIM) begin
                fin      = 1'b1;
                fin_code = 3'd1;
              end
            end else if (eng_rx == 8'h00) begin
              cnt_d   = 16'd0;
              state_d = S_TOKEN;
            end else begin
              fin      = 1'b1;
              fin_code = 3'd2;
            end
          end
          S_TOKEN: begin
            if (eng_rx == 8'hFF) begin
              cnt_d = cnt_q + 16'd1;
              if (cnt_q + 16'd1 == TOK_LIM) begin
                fin      = 1'b1;
                fin_code = 3'd3;
              end
            end else if (eng_rx == 8'hFE) begin
              cnt_d   = 16'd0;
              ph_d    = PH_CLR;
              state_d = S_DATA;
            end else begin
              fin      = 1'b1;
              fin_code = 3'd4;
            end
          end
          S_DATA: begin
            we_d  = 1'b1;
            bd_d  = eng_rx;
            adr_d = cnt_q[8:0];
            if (cnt_q == 16'd511) begin
              cnt_d   = 16'd0;
              state_d = S_CRC;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
          S_CRC: begin
            if (cnt_q == 16'd0) begin
              cnt_d = 16'd1;
            end else begin
              state_d = S_TAIL;
`ifdef SDCARD_SEQ_CRC_EN
              if (eng_crc16 != 16'h0000) begin
                fin      = 1'b1;
                fin_code = 3'd5;
              end
`endif
            end
          end
          default: begin
            fin      = 1'b1;
            fin_code = 3'd0;
          end
        endcase
      end

      if (fin) begin
        state_d = S_IDLE;
        ph_d    = PH_GO;
        cs_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        err_d   = fin_code;
        abort_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ph_q    <= PH_GO;
      cnt_q   <= 16'd0;
      tx_q    <= 8'h00;
      err_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      abort_q <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 9'd0;
      bd_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      abort_q <= abort_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      bd_q    <= bd_d;
    end
  end

  always_ff @(posedge clk) begin
    lba_q <= lba_d;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err_code    = err_q;
  assign sd_cs       = cs_q;
  assign eng_go      = (state_q != S_IDLE) && (ph_q == PH_GO);
  assign eng_tx      = tx_q;
  assign eng_crc_clr = (state_q == S_DATA) && (ph_q == PH_CLR);
  assign buf_we      = we_q;
  assign buf_adr     = adr_q;
  assign buf_d       = bd_q;

endmodule

// File: tb/tb_sdcard_block_seq.sv
// Scoreboard bench for sdcard_block_seq: a byte-engine/card model feeds responses, a monitor checks outputs.
module tb_sdcard_block_seq;
  localparam int BUSY_LEN = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] lba = 32'd0;
  logic        busy, done, sd_cs, eng_go, eng_crc_clr, buf_we;
  logic [2:0]  err_code;
  logic [7:0]  eng_tx, buf_d;
  logic [8:0]  buf_adr;
  logic        eng_busy;
  logic [7:0]  eng_rx = 8'hFF;
  logic [15:0] eng_crc16;

  sdcard_block_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .lba(lba),
    .busy(busy), .done(done), .err_code(err_code), .sd_cs(sd_cs),
    .eng_go(eng_go), .eng_tx(eng_tx), .eng_busy(eng_busy), .eng_rx(eng_rx),
    .eng_crc16(eng_crc16), .eng_crc_clr(eng_crc_clr),
    .buf_we(buf_we), .buf_adr(buf_adr), .buf_d(buf_d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int go_cnt = 0;
  int done_cnt = 0;
  logic [7:0]  exp_tx[$];
  logic [16:0] exp_wr[$];
  logic [2:0]  exp_done[$];
  logic [7:0]  resp[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [7:0] pick_rx(input int idx);
    if (idx < 6 || resp.size() == 0) return 8'hFF;
    return resp.pop_front();
  endfunction

  // Engine + card model: the first 6 bytes of a selection are the command, later bytes pop resp.
  int          m_n = 0, m_idx = 0, m_left = 0;
  logic        m_busy = 1'b0, m_pend = 1'b0;
  logic [15:0] m_base = 16'h0000;
  assign eng_busy  = m_busy;
  assign eng_crc16 = m_pend ? crc_upd(m_base, eng_rx) : m_base;

  always @(posedge clk) begin
    if (!sd_cs) m_n <= 0;
    if (m_pend) begin
      m_base <= crc_upd(m_base, eng_rx);
      m_pend <= 1'b0;
    end
    if (eng_go) begin
      m_busy <= 1'b1;
      m_left <= BUSY_LEN;
      m_idx  <= m_n;
      m_n    <= m_n + 1;
      go_cnt <= go_cnt + 1;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        eng_rx <= pick_rx(m_idx);
        m_pend <= 1'b1;
      end
    end
    if (eng_crc_clr) begin
      m_base <= 16'h0000;
      m_pend <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (eng_go) begin
        if (exp_tx.size() == 0) chk("tx_extra", {24'd0, eng_tx}, 32'h1FF);
        else chk("tx_byte", {24'd0, eng_tx}, {24'd0, exp_tx.pop_front()});
        chk("cs_during_go", {31'd0, sd_cs}, 32'd1);
      end
      if (buf_we) begin
        if (exp_wr.size() == 0) chk("wr_extra", {15'd0, buf_adr, buf_d}, 32'h1FFFF);
        else chk("buf_write", {15'd0, buf_adr, buf_d}, {15'd0, exp_wr.pop_front()});
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        if (exp_done.size() == 0) chk("done_extra", {29'd0, err_code}, 32'hF);
        else chk("err_code", {29'd0, err_code}, {29'd0, exp_done.pop_front()});
        chk("cs_at_done", {31'd0, sd_cs}, 32'd0);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic push_cmd(input logic [31:0] a);
    exp_tx.push_back(8'h51);
    exp_tx.push_back(a[31:24]);
    exp_tx.push_back(a[23:16]);
    exp_tx.push_back(a[15:8]);
    exp_tx.push_back(a[7:0]);
    exp_tx.push_back(8'h01);
  endtask

  task automatic push_ff(input int n);
    for (int i = 0; i < n; i++) exp_tx.push_back(8'hFF);
  endtask

  // Card sends n_data bytes i[7:0] (bit 0 flipped at bad_idx) and, if with_crc, the clean CRC.
  task automatic push_block(input int n_data, input int n_wr, input int bad_idx, input bit with_crc);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'h0000;
    for (int i = 0; i < n_data; i++) begin
      b = i[7:0];
      c = crc_upd(c, b);
      if (i == bad_idx) b = b ^ 8'h01;
      resp.push_back(b);
      if (i < n_wr) exp_wr.push_back({i[8:0], b});
    end
    if (with_crc) begin
      resp.push_back(c[15:8]);
      resp.push_back(c[7:0]);
    end
  endtask

  task automatic do_start(input logic [31:0] a);
    @(negedge clk);
    lba   = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string nm);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (done_cnt != d0) seen = 1'b1;
    end
    if (!seen) chk({nm, "_done_timeout"}, 32'd0, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_go(input int target);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (go_cnt >= target) seen = 1'b1;
    end
    if (!seen) chk("go_timeout", 32'd0, 32'd1);
  endtask

  task automatic end_test(input string nm);
    chk({nm, "_tx_left"}, exp_tx.size(), 32'd0);
    chk({nm, "_wr_left"}, exp_wr.size(), 32'd0);
    chk({nm, "_done_left"}, exp_done.size(), 32'd0);
    chk({nm, "_cs_idle"}, {31'd0, sd_cs}, 32'd0);
    exp_tx.delete();
    exp_wr.delete();
    exp_done.delete();
    resp.delete();
  endtask

  initial begin
    int base;
    int d0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cs", {31'd0, sd_cs}, 32'd0);
    chk("rst_go", {31'd0, eng_go}, 32'd0);
    chk("rst_crc_clr", {31'd0, eng_crc_clr}, 32'd0);
    chk("rst_we", {31'd0, buf_we}, 32'd0);
    chk("rst_err", {29'd0, err_code}, 32'd0);
    chk("rst_adr", {23'd0, buf_adr}, 32'd0);
    chk("rst_bd", {24'd0, buf_d}, 32'd0);
    chk("rst_tx", {24'd0, eng_tx}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good read: R1 after 2 polls, token after 1 poll.
    resp.push_back(8'hFF); resp.push_back(8'hFF); resp.push_back(8'h00);
    resp.push_back(8'hFF); resp.push_back(8'hFE);
    push_block(512, 512, -1, 1'b1);
    push_cmd(32'h00001234); push_ff(3 + 2 + 512 + 2 + 1);
    exp_done.push_back(3'd0);
    do_start(32'h00001234);
    wait_done("good");
    end_test("good");

    // Card never answers.
    push_cmd(32'h00000010); push_ff(8);
    exp_done.push_back(3'd1);
    do_start(32'h00000010);
    wait_done("r1_timeout");
    end_test("r1_timeout");

    // R1 error response.
    resp.push_back(8'h05);
    push_cmd(32'h00000020); push_ff(1);
    exp_done.push_back(3'd2);
    do_start(32'h00000020);
    wait_done("r1_err");
    end_test("r1_err");

    // Bad data token.
    resp.push_back(8'h00); resp.push_back(8'hFC);
    push_cmd(32'h00000030); push_ff(2);
    exp_done.push_back(3'd4);
    do_start(32'h00000030);
    wait_done("bad_token");
    end_test("bad_token");

    // Corrupted data byte 7.
    resp.push_back(8'h00); resp.push_back(8'hFE);
    push_block(512, 512, 7, 1'b1);
    push_cmd(32'h00000040); push_ff(2 + 512 + 2);
`ifdef SDCARD_SEQ_CRC_EN
    exp_done.push_back(3'd5);
`else
    push_ff(1);
    exp_done.push_back(3'd0);
`endif
    do_start(32'h00000040);
    wait_done("crc");
    end_test("crc");

    // Abort during DATA at index 100, plus an ignored start while busy.
    resp.push_back(8'h00); resp.push_back(8'hFE);
    push_block(512, 100, -1, 1'b0);
    push_cmd(32'h00000050); push_ff(2 + 101);
    exp_done.push_back(3'd6);
    base = go_cnt;
    do_start(32'h00000050);
    wait_go(base + 3);
    lba = 32'hFFFFFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_go(base + 109);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort");
    repeat (20) @(negedge clk);
    end_test("abort");

    // Reset in the middle of token polling.
    resp.push_back(8'h00);
    for (int i = 0; i < 40; i++) resp.push_back(8'hFF);
    push_cmd(32'h00000060); push_ff(1 + 5);
    base = go_cnt;
    d0 = done_cnt;
    do_start(32'h00000060);
    wait_go(base + 12);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_cs", {31'd0, sd_cs}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_mid_no_done", done_cnt, d0);
    end_test("rst_mid");

    // Clean read after the reset, R1 and token on the first poll.
    resp.push_back(8'h00); resp.push_back(8'hFE);
    push_block(512, 512, -1, 1'b1);
    push_cmd(32'hA1B2C3D4); push_ff(1 + 1 + 512 + 2 + 1);
    exp_done.push_back(3'd0);
    do_start(32'hA1B2C3D4);
    wait_done("after_rst");
    end_test("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
